// File: rtl/oscill_nios_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer: one registered 16x16 unsigned multiplier is
// time-shared over the four half-word partial products, then signed-corrected.
module oscill_nios_mul_seq #(
    parameter int unsigned MUL_LAT   = 1,
    parameter bit          FAST_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [1:0]  op,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StFix,
        StDone
    } state_e;

    localparam logic [1:0] OpMul = 2'b00;
    localparam logic [1:0] OpSs  = 2'b01;
    localparam logic [1:0] OpSu  = 2'b10;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;

    // Multiplier pipeline: product, partial-product index and valid tag per stage.
    logic [MUL_LAT-1:0][31:0] prod_q, prod_d;
    logic [MUL_LAT-1:0][1:0]  psel_q, psel_d;
    logic [MUL_LAT-1:0]       pvld_q, pvld_d;

    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] prod_out;
    logic [1:0]  psel_out;
    logic        pvld_out;
    logic [63:0] addend;
    logic [31:0] corr;
    logic [1:0]  issue_last;
    logic        zero_req;

    // cnt bit 1 selects the A half, bit 0 the B half: ll, lh, hl, hh.
    assign mul_a = cnt_q[1] ? a_q[31:16] : a_q[15:0];
    assign mul_b = cnt_q[0] ? b_q[31:16] : b_q[15:0];

    assign prod_out = prod_q[MUL_LAT-1];
    assign psel_out = psel_q[MUL_LAT-1];
    assign pvld_out = pvld_q[MUL_LAT-1];

    assign issue_last = (op_q == OpMul) ? 2'd2 : 2'd3;
    assign zero_req   = FAST_ZERO && ((a_q == 32'd0) || (b_q == 32'd0));

    always_comb begin
        prod_d    = prod_q;
        psel_d    = psel_q;
        pvld_d    = pvld_q;
        prod_d[0] = {16'd0, mul_a} * {16'd0, mul_b};
        psel_d[0] = cnt_q;
        pvld_d[0] = (state_q == StIssue) && !zero_req;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            prod_d[i] = prod_q[i-1];
            psel_d[i] = psel_q[i-1];
            pvld_d[i] = pvld_q[i-1];
        end
    end

    always_comb begin
        addend = 64'd0;
        if (pvld_out) begin
            unique case (psel_out)
                2'd0:    addend = {32'd0, prod_out};
                2'd1,
                2'd2:    addend = {16'd0, prod_out, 16'd0};
                default: addend = {prod_out, 32'd0};
            endcase
        end
    end

    // Two's-complement correction of the unsigned high word.
    always_comb begin
        corr = 32'd0;
        if (op_q == OpSs) begin
            if (a_q[31]) corr = corr + b_q;
            if (b_q[31]) corr = corr + a_q;
        end else if (op_q == OpSu) begin
            if (a_q[31]) corr = b_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q + addend;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = op;
                    acc_d   = 64'd0;
                    cnt_d   = 2'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (zero_req) begin
                    result_d = 32'd0;
                    state_d  = StDone;
                end else if (cnt_q == issue_last) begin
                    cnt_d   = 2'd0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StDrain: begin
                if (cnt_q == 2'(MUL_LAT - 1)) begin
                    cnt_d = 2'd0;
                    if (op_q == OpMul) begin
                        result_d = acc_d[31:0];
                        state_d  = StDone;
                    end else begin
                        state_d = StFix;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StFix: begin
                result_d = acc_q[63:32] - corr;
                state_d  = StDone;
            end
            StDone: begin
                if (result_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= 2'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            prod_q   <= '0;
            psel_q   <= '0;
            pvld_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            prod_q   <= prod_d;
            psel_q   <= psel_d;
            pvld_q   <= pvld_d;
        end
    end

    assign start_ready  = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign result_valid = (state_q == StDone);
    assign result       = result_q;

endmodule

// File: tb/tb_oscill_nios_mul_seq.sv
// Directed self-checking bench for oscill_nios_mul_seq with MUL_LAT=1, FAST_ZERO=1.
module tb_oscill_nios_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [1:0]  op;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    oscill_nios_mul_seq #(
        .MUL_LAT  (1),
        .FAST_ZERO(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .src1        (src1),
        .src2        (src2),
        .op          (op),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result      (result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a request, scrambles the inputs after accept, and waits for result_valid.
    task automatic request(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit busy_ok;
        start_valid = 1'b1;
        src1 = a;
        src2 = b;
        op = o;
        check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        tick();
        start_valid = 1'b0;
        src1 = $urandom;
        src2 = $urandom;
        op = ~o;
        lat = 0;
        busy_ok = 1'b1;
        while (!result_valid && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(result), 64'(exp));
        check({tag, "_busy"}, 64'(busy_ok && busy), 64'd1);
    endtask

    task automatic take(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, "_taken"}, 64'(result_valid), 64'd0);
    endtask

    initial begin
        int rv_seen;
        reset = 1'b1;
        start_valid = 1'b0;
        result_ready = 1'b0;
        src1 = '0;
        src2 = '0;
        op = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);

        // Stray result_ready while nothing is pending.
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("stray_ready_valid", 64'(result_valid), 64'd0);
        check("stray_ready_idle", 64'(start_ready), 64'd1);

        request("mul_lo", 2'b00, 32'h0001_0002, 32'h0003_0004, 32'h000A_0008, 4);
        take("mul_lo");
        request("uu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6);
        take("uu_ff");
        request("ss_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 6);
        take("ss_ff");
        request("su_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6);
        take("su_ff");
        request("ss_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 6);
        take("ss_min");
        // 0x12345678 * 0x9ABCDEF0 = 0x0B00EA4E_242D2080
        request("uu_mix", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 6);
        take("uu_mix");
        // Signed view: B negative, so high word drops by A.
        request("ss_mix", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'hF8CC_93D6, 6);
        take("ss_mix");

        // Backpressure with a competing request held on the start side.
        request("bp_first", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 6);
        start_valid = 1'b1;
        src1 = 32'd3;
        src2 = 32'd5;
        op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_result", 64'(result), 64'h1);
            check("bp_hold_valid", 64'(result_valid), 64'd1);
            check("bp_start_ready", 64'(start_ready), 64'd0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("bp_bubble_ready", 64'(start_ready), 64'd1);
        check("bp_bubble_valid", 64'(result_valid), 64'd0);
        request("bp_second", 2'b00, 32'd3, 32'd5, 32'd15, 4);
        take("bp_second");

        // Zero operand shortcut.
        request("fast_zero", 2'b11, 32'd0, 32'h1234_5678, 32'd0, 1);
        take("fast_zero");

        // Reset in the ISSUE cycle with cnt=2 drops the operation.
        start_valid = 1'b1;
        src1 = 32'h1234_5678;
        src2 = 32'h9ABC_DEF0;
        op = 2'b01;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_idle", 64'(start_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        rv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (result_valid) rv_seen++;
            tick();
        end
        check("midrst_no_result", 64'(rv_seen), 64'd0);
        request("post_rst", 2'b00, 32'd3, 32'd5, 32'd15, 4);
        take("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
